// File: rtl/axis_sub_one.sv
// AXI4-Stream lane decoder: subtracts 1 from every byte lane; 1-cycle latency, two-entry skid buffer.
// Backpressure: s_axis_tready drops only when the skid entry is full; build option AXIS_SUB_ONE_KEEP_MASK_EN zeroes tkeep=0 lanes.
module axis_sub_one (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] beat_count
);

  // Encoding chosen so bit0 is OUT.valid and bit1 is SKID.valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t      state, next_state;
  logic [31:0] out_dat, skid_dat, count_q, dec_dat;
  logic [3:0]  out_keep, skid_keep;
  logic        in_xfer, out_xfer;
  logic        load_out_in, load_out_skid, load_skid;

  assign s_axis_tready = ~state[1] & ~reset;
  assign m_axis_tvalid = state[0];
  assign m_axis_tdata  = out_dat;
  assign m_axis_tkeep  = out_keep;
  assign beat_count    = count_q;

  assign in_xfer  = s_axis_tvalid & s_axis_tready;
  assign out_xfer = m_axis_tvalid & m_axis_tready;

  always_comb begin
    dec_dat = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef AXIS_SUB_ONE_KEEP_MASK_EN
      dec_dat[8*i +: 8] = s_axis_tkeep[i] ? (s_axis_tdata[8*i +: 8] - 8'h01) : 8'h00;
`else
      dec_dat[8*i +: 8] = s_axis_tdata[8*i +: 8] - 8'h01;
`endif
    end
  end

  always_comb begin
    next_state    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          next_state  = ONE;
          load_out_in = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_out_in = 1'b1;
        end else if (out_xfer) begin
          next_state = EMPTY;
        end else if (in_xfer) begin
          next_state = TWO;
          load_skid  = 1'b1;
        end
      end
      TWO: begin
        if (out_xfer) begin
          next_state    = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_dat   <= '0;
      out_keep  <= '0;
      skid_dat  <= '0;
      skid_keep <= '0;
      count_q   <= '0;
    end else begin
      if (load_out_in) begin
        out_dat  <= dec_dat;
        out_keep <= s_axis_tkeep;
      end else if (load_out_skid) begin
        out_dat  <= skid_dat;
        out_keep <= skid_keep;
      end
      // Skid entry is zeroed when drained so an empty skid always reads as zero.
      if (load_skid) begin
        skid_dat  <= dec_dat;
        skid_keep <= s_axis_tkeep;
      end else if (load_out_skid) begin
        skid_dat  <= '0;
        skid_keep <= '0;
      end
      if (out_xfer) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_sub_one.sv
// Directed self-checking bench for axis_sub_one; inputs driven and outputs sampled on the falling edge.
module tb_axis_sub_one;

  logic        clock;
  logic        reset;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] beat_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 32'd0;

  axis_sub_one dut (
    .clock         (clock),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .beat_count    (beat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    @(negedge clock);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h want 00000000", m_axis_tdata); end
    checks++; if (m_axis_tkeep !== 4'h0) begin errors++; $display("FAIL reset_tkeep: got %h want 0", m_axis_tkeep); end
    checks++; if (beat_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", beat_count); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready_held: got %b want 0", s_axis_tready); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready_release: got %b want 1", s_axis_tready); end
  endtask

  task automatic test_single();
    s_axis_tdata = 32'h00010203; s_axis_tkeep = 4'hF; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    @(negedge clock);
    s_axis_tvalid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid: got %b want 1", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 32'hFF000102) begin errors++; $display("FAIL single_tdata: got %h want ff000102", m_axis_tdata); end
    checks++; if (m_axis_tkeep !== 4'hF) begin errors++; $display("FAIL single_tkeep: got %h want f", m_axis_tkeep); end
    @(negedge clock);
    exp_count = exp_count + 32'd1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", m_axis_tvalid); end
    checks++; if (beat_count !== exp_count) begin errors++; $display("FAIL single_count: got %0d want %0d", beat_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] din [16];
    for (int i = 0; i < 16; i++) din[i] = 32'h10203040 + i * 32'h04030201;
    m_axis_tready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        // Every lane of din is >= 1, so per-lane subtraction equals a plain 32-bit subtract.
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== din[i-1] - 32'h01010101)
          begin errors++; $display("FAIL stream_beat%0d: got v=%b %h want v=1 %h", i-1, m_axis_tvalid, m_axis_tdata, din[i-1] - 32'h01010101); end
      end
      if (i < 16) begin
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL stream_tready%0d: got %b want 1", i, s_axis_tready); end
        s_axis_tdata = din[i]; s_axis_tkeep = 4'hF; s_axis_tvalid = 1'b1;
        @(negedge clock);
      end
    end
    s_axis_tvalid = 1'b0;
    @(negedge clock);
    exp_count = exp_count + 32'd16;
    checks++; if (beat_count !== exp_count) begin errors++; $display("FAIL stream_count: got %0d want %0d", beat_count, exp_count); end
  endtask

  task automatic test_backpressure();
    m_axis_tready = 1'b0;
    s_axis_tdata = 32'h0A0B0C0D; s_axis_tkeep = 4'hF; s_axis_tvalid = 1'b1;
    @(negedge clock);
    checks++; if (m_axis_tdata !== 32'h090A0B0C || s_axis_tready !== 1'b1)
      begin errors++; $display("FAIL bp_a_load: got %h rdy=%b want 090a0b0c rdy=1", m_axis_tdata, s_axis_tready); end
    s_axis_tdata = 32'h01000100; s_axis_tkeep = 4'h3;
    @(negedge clock);
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_full_tready: got %b want 0", s_axis_tready); end
    s_axis_tdata = 32'hFFFFFFFF; s_axis_tkeep = 4'h8;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++; if (m_axis_tdata !== 32'h090A0B0C || m_axis_tkeep !== 4'hF || m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0)
        begin errors++; $display("FAIL bp_stall%0d: got %h/%h v=%b rdy=%b want 090a0b0c/f v=1 rdy=0", k, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, s_axis_tready); end
    end
    m_axis_tready = 1'b1;
    @(negedge clock);
    checks++; if (m_axis_tdata !== 32'h00FF00FF || m_axis_tkeep !== 4'h3 || m_axis_tvalid !== 1'b1)
      begin errors++; $display("FAIL bp_b_out: got %h/%h v=%b want 00ff00ff/3 v=1", m_axis_tdata, m_axis_tkeep, m_axis_tvalid); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL bp_refill_tready: got %b want 1", s_axis_tready); end
    @(negedge clock);
    s_axis_tvalid = 1'b0;
    checks++; if (m_axis_tdata !== 32'hFEFEFEFE || m_axis_tkeep !== 4'h8 || m_axis_tvalid !== 1'b1)
      begin errors++; $display("FAIL bp_c_out: got %h/%h v=%b want fefefefe/8 v=1", m_axis_tdata, m_axis_tkeep, m_axis_tvalid); end
    @(negedge clock);
    exp_count = exp_count + 32'd3;
    checks++; if (m_axis_tvalid !== 1'b0 || beat_count !== exp_count)
      begin errors++; $display("FAIL bp_done: got v=%b count=%0d want v=0 count=%0d", m_axis_tvalid, beat_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    m_axis_tready = 1'b0;
    s_axis_tdata = 32'h55555555; s_axis_tkeep = 4'hF; s_axis_tvalid = 1'b1;
    @(negedge clock);
    s_axis_tdata = 32'h66666666;
    @(negedge clock);
    s_axis_tvalid = 1'b0;
    checks++; if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1)
      begin errors++; $display("FAIL rmid_two: got rdy=%b v=%b want rdy=0 v=1", s_axis_tready, m_axis_tvalid); end
    #2 reset = 1'b1;
    #1;
    exp_count = 32'd0;
    checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0 || s_axis_tready !== 1'b0)
      begin errors++; $display("FAIL rmid_async: got v=%b %h rdy=%b want v=0 00000000 rdy=0", m_axis_tvalid, m_axis_tdata, s_axis_tready); end
    checks++; if (beat_count !== 32'h0) begin errors++; $display("FAIL rmid_count: got %0d want 0", beat_count); end
    @(negedge clock);
    reset = 1'b0;
    m_axis_tready = 1'b1;
    s_axis_tdata = 32'h11111111; s_axis_tvalid = 1'b1;
    @(negedge clock);
    s_axis_tvalid = 1'b0;
    checks++; if (m_axis_tdata !== 32'h10101010 || m_axis_tvalid !== 1'b1)
      begin errors++; $display("FAIL rmid_new: got %h v=%b want 10101010 v=1", m_axis_tdata, m_axis_tvalid); end
    @(negedge clock);
    exp_count = 32'd1;
    checks++; if (beat_count !== exp_count || m_axis_tvalid !== 1'b0)
      begin errors++; $display("FAIL rmid_single_out: got count=%0d v=%b want count=1 v=0", beat_count, m_axis_tvalid); end
  endtask

  task automatic test_keep_mask();
    logic [31:0] exp_dat;
`ifdef AXIS_SUB_ONE_KEEP_MASK_EN
    exp_dat = 32'h00210043;
`else
    exp_dat = 32'h10213243;
`endif
    m_axis_tready = 1'b1;
    s_axis_tdata = 32'h11223344; s_axis_tkeep = 4'b0101; s_axis_tvalid = 1'b1;
    @(negedge clock);
    s_axis_tvalid = 1'b0;
    checks++; if (m_axis_tdata !== exp_dat) begin errors++; $display("FAIL keep_data: got %h want %h", m_axis_tdata, exp_dat); end
    checks++; if (m_axis_tkeep !== 4'b0101) begin errors++; $display("FAIL keep_pass: got %b want 0101", m_axis_tkeep); end
    @(negedge clock);
    exp_count = exp_count + 32'd1;
  endtask

  task automatic test_count_wrap();
    force dut.count_q = 32'hFFFFFFFF;
    #1 release dut.count_q;
    #1;
    checks++; if (beat_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffffffff", beat_count); end
    @(negedge clock);
    m_axis_tready = 1'b1;
    s_axis_tdata = 32'h00000000; s_axis_tkeep = 4'hF; s_axis_tvalid = 1'b1;
    @(negedge clock);
    s_axis_tvalid = 1'b0;
    checks++; if (m_axis_tdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_data: got %h want ffffffff", m_axis_tdata); end
    @(negedge clock);
    checks++; if (beat_count !== 32'h0) begin errors++; $display("FAIL wrap_count: got %h want 00000000", beat_count); end
  endtask

  initial begin
    reset = 1'b1;
    s_axis_tdata = 32'h0; s_axis_tkeep = 4'h0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_keep_mask();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
